// File: rtl/sr_latch_bist.sv
// Built-in self-test controller for an SR latch: drives a fixed nine-step S/R sequence and checks Q/Q_bar.
// Optional macro SR_BIST_INVALID_CHECK_EN: also checks step 6 (S=R=1) against NOR-latch behaviour (Q=Q_bar=0).
module sr_latch_bist #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             S,
  output logic             R,
  input  logic             Q,
  input  logic             Q_bar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_step,
  output logic [3:0]       step_idx
);

  localparam int unsigned   DW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_SMP  = DW'(SETTLE_CYCLES);
  localparam logic [3:0]    LAST_STEP  = 4'd8;
  localparam logic [3:0]    NO_FAIL    = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [3:0]       step_q, step_d;
  logic             s_q, s_d, r_q, r_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             mismatch;

  // Step 6 (1,1) is followed directly by step 7 (1,0) so the latch never races out of 1,1.
  function automatic logic [1:0] step_drive(input logic [3:0] idx);
    case (idx)
      4'd0:    step_drive = 2'b01;
      4'd2:    step_drive = 2'b10;
      4'd4:    step_drive = 2'b01;
      4'd6:    step_drive = 2'b11;
      4'd7:    step_drive = 2'b10;
      4'd8:    step_drive = 2'b01;
      default: step_drive = 2'b00;
    endcase
  endfunction

  function automatic logic step_exp_q(input logic [3:0] idx);
    step_exp_q = (idx == 4'd2) || (idx == 4'd3) || (idx == 4'd7);
  endfunction

  function automatic logic step_exp_qb(input logic [3:0] idx);
    step_exp_qb = (idx == 4'd6) ? 1'b0 : ~step_exp_q(idx);
  endfunction

  function automatic logic step_checked(input logic [3:0] idx);
`ifdef SR_BIST_INVALID_CHECK_EN
    step_checked = (idx <= LAST_STEP);
`else
    step_checked = (idx != 4'd6);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
      step_q  <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= NO_FAIL;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    step_d   = step_q;
    s_d      = s_q;
    r_d      = r_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          dwell_d    = '0;
          step_d     = '0;
          {s_d, r_d} = step_drive(4'd0);
          err_d      = '0;
          fail_d     = NO_FAIL;
        end
      end
      RUN: begin
        if ((dwell_q == DWELL_SMP) && step_checked(step_q)) begin
          mismatch = (Q != step_exp_q(step_q)) || (Q_bar != step_exp_qb(step_q));
        end
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (fail_q == NO_FAIL) fail_d = step_q;
        end
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            s_d     = 1'b0;
            r_d     = 1'b0;
          end else begin
            step_d     = step_q + 4'd1;
            {s_d, r_d} = step_drive(step_q + 4'd1);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S         = s_q;
  assign R         = r_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (err_q == '0);
  assign err_count = err_q;
  assign fail_step = fail_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_sr_latch_bist.sv
// Scoreboard bench for sr_latch_bist: a behavioural NOR-latch LUT with injectable faults feeds two DUT configurations.
module tb_sr_latch_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic       S0, R0, Q0, Qb0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] fail0, step0;
  logic       S1, R1, Q1, Qb1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [3:0] fail1, step1;

  int which = 0;
  int mode  = 0;  // 0 ideal, 1 Q stuck 0, 2 Q stuck 1, 3 Q wrong during step 7
  int checks = 0;
  int errors = 0;

  logic lq0 = 1'b0, lq1 = 1'b0;
  always @(S0 or R0) if (S0 && !R0) lq0 = 1'b1; else if (!S0 && R0) lq0 = 1'b0;
  always @(S1 or R1) if (S1 && !R1) lq1 = 1'b1; else if (!S1 && R1) lq1 = 1'b0;

  function automatic logic [1:0] lut_out(input logic s, input logic r, input logic lq,
                                         input int m, input logic [3:0] st);
    logic q, qb;
    q  = (s && r) ? 1'b0 : lq;
    qb = (s && r) ? 1'b0 : ~lq;
    case (m)
      1: begin q = 1'b0; qb = 1'b1; end
      2: begin q = 1'b1; qb = 1'b0; end
      3: if (st == 4'd7) q = ~q;
      default: ;
    endcase
    return {q, qb};
  endfunction

  assign {Q0, Qb0} = lut_out(S0, R0, lq0, (which == 0) ? mode : 0, step0);
  assign {Q1, Qb1} = lut_out(S1, R1, lq1, (which == 1) ? mode : 0, step1);

  sr_latch_bist u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .S(S0), .R(R0), .Q(Q0), .Q_bar(Qb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_step(fail0), .step_idx(step0)
  );

  sr_latch_bist #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .S(S1), .R(R1), .Q(Q1), .Q_bar(Qb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_step(fail1), .step_idx(step1)
  );

  logic       Sm, Rm, busy_m, done_m, pass_m;
  logic [7:0] err_m;
  logic [3:0] fail_m, step_m;
  always_comb begin
    if (which == 0) begin
      Sm = S0; Rm = R0; busy_m = busy0; done_m = done0; pass_m = pass0;
      err_m = err0; fail_m = fail0; step_m = step0;
    end else begin
      Sm = S1; Rm = R1; busy_m = busy1; done_m = done1; pass_m = pass1;
      err_m = {6'b0, err1}; fail_m = fail1; step_m = step1;
    end
  end

  typedef struct {
    logic [7:0] err;
    logic [3:0] fail;
    logic       pass;
    int         busy;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic [7:0] e, input logic [3:0] f, input logic p, input int b);
    exp_t x;
    x.err = e; x.fail = f; x.pass = p; x.busy = b;
    sb.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic run(input string tag, input int pulse_at);
    exp_t x;
    int   cyc;
    pulse_start();
    check({tag, ":first_step"}, 32'(step_m), 32'd0);
    check({tag, ":first_SR"}, 32'({Sm, Rm}), 32'b01);
    check({tag, ":first_err"}, 32'(err_m), 32'd0);
    check({tag, ":first_fail"}, 32'(fail_m), 32'hF);
    check({tag, ":first_busy_done"}, 32'({busy_m, done_m}), 32'b10);
    cyc = 0;
    while (!done_m && cyc < 200) begin
      if (busy_m) cyc++;
      if (pulse_at >= 0 && cyc == pulse_at + 1) begin
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      if (pulse_at >= 0 && cyc == 17) check({tag, ":step_on_schedule"}, 32'(step_m), 32'd4);
      @(negedge clk);
    end
    start0 = 1'b0; start1 = 1'b0;
    check({tag, ":done_reached"}, 32'(done_m), 32'd1);
    check({tag, ":sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, ":busy_cycles"}, 32'(cyc), 32'(x.busy));
      check({tag, ":err_count"}, 32'(err_m), 32'(x.err));
      check({tag, ":fail_step"}, 32'(fail_m), 32'(x.fail));
      check({tag, ":pass"}, 32'(pass_m), 32'(x.pass));
    end
    check({tag, ":end_step"}, 32'(step_m), 32'd8);
    check({tag, ":end_SR_busy"}, 32'({Sm, Rm, busy_m}), 32'b000);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      which = w;
      #1;
      check("rst_SR", 32'({Sm, Rm}), 32'b00);
      check("rst_busy_done_pass", 32'({busy_m, done_m, pass_m}), 32'b000);
      check("rst_err", 32'(err_m), 32'd0);
      check("rst_fail", 32'(fail_m), 32'hF);
      check("rst_step", 32'(step_m), 32'd0);
    end
    which = 0;
    @(negedge clk);
    rst = 1'b0;

    mode = 0;
    expect_run(8'd0, 4'hF, 1'b1, 36);
    run("ideal", -1);

    mode = 1;
`ifdef SR_BIST_INVALID_CHECK_EN
    expect_run(8'd4, 4'd2, 1'b0, 36);
`else
    expect_run(8'd3, 4'd2, 1'b0, 36);
`endif
    run("q_stuck0", -1);

    mode = 0;
    expect_run(8'd0, 4'hF, 1'b1, 36);
    run("start_while_busy", 13);

    // Abort at step 4 dwell 1 (cycle 17) after steps 0 and 1 have already mismatched.
    mode = 2;
    pulse_start();
    repeat (17) @(negedge clk);
    check("abort_pre_step", 32'(step_m), 32'd4);
    check("abort_pre_err", 32'(err_m), 32'd2);
    rst = 1'b1;
    #1;
    check("abort_SR", 32'({Sm, Rm}), 32'b00);
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_err", 32'(err_m), 32'd0);
    check("abort_fail", 32'(fail_m), 32'hF);
    check("abort_step", 32'(step_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    expect_run(8'd0, 4'hF, 1'b1, 36);
    run("after_abort", -1);

    which = 1;
    mode = 2;
    expect_run(8'd3, 4'd0, 1'b0, 18);
    run("q_stuck1_sat", -1);

    mode = 3;
    expect_run(8'd1, 4'd7, 1'b0, 18);
    run("glitch_step7", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
